// File: rtl/mips_ex_datapath_core.sv
// MIPS ID decoder, EX-stage ALU and EX/ME pipeline register.
// Decoder and ALU are combinational; the EX/ME register has a synchronous active-low reset.
module mips_ex_datapath_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [3:0]  ctrl_alu,
    output logic        ctrl_reg_dst,
    output logic [1:0]  ctrl_src_a,
    output logic [1:0]  ctrl_src_b,
    output logic        ctrl_mem2reg,
    output logic        ctrl_ext,
    output logic        ctrl_reg_wr,
    output logic        ctrl_mem_wr,
    output logic [1:0]  ctrl_branch,
    output logic        ctrl_jump,
    input  logic [3:0]  ex_alu_op,
    input  logic [31:0] ex_in_a,
    input  logic [31:0] ex_in_b,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dst,
    input  logic        ex_mem2reg,
    input  logic        ex_mem_wr,
    input  logic        ex_reg_wr,
    output logic [31:0] alu_out,
    output logic [31:0] me_alu_out,
    output logic [31:0] me_store_data,
    output logic [4:0]  me_dst,
    output logic        me_mem2reg,
    output logic        me_mem_wr,
    output logic        me_reg_wr
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [1:0] SRC_A_RS    = 2'd0;
    localparam logic [1:0] SRC_A_16    = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;

    logic [4:0] shamt;

    always_comb begin
        ctrl_alu     = ALU_ADD;
        ctrl_reg_dst = 1'b0;
        ctrl_src_a   = SRC_A_RS;
        ctrl_src_b   = 2'd0;
        ctrl_mem2reg = 1'b0;
        ctrl_ext     = 1'b0;
        ctrl_reg_wr  = 1'b0;
        ctrl_mem_wr  = 1'b0;
        ctrl_branch  = 2'b00;
        ctrl_jump    = 1'b0;
        case (op)
            6'h00: begin
                ctrl_reg_dst = 1'b1;
                ctrl_reg_wr  = 1'b1;
                case (funct)
                    6'h20, 6'h21: ctrl_alu = ALU_ADD;
                    6'h22, 6'h23: ctrl_alu = ALU_SUB;
                    6'h24: ctrl_alu = ALU_AND;
                    6'h25: ctrl_alu = ALU_OR;
                    6'h26: ctrl_alu = ALU_XOR;
                    6'h27: ctrl_alu = ALU_NOR;
                    6'h2A: ctrl_alu = ALU_SLT;
                    6'h2B: ctrl_alu = ALU_SLTU;
                    6'h00: begin ctrl_alu = ALU_SLL; ctrl_src_a = SRC_A_SHAMT; end
                    6'h02: begin ctrl_alu = ALU_SRL; ctrl_src_a = SRC_A_SHAMT; end
                    6'h03: begin ctrl_alu = ALU_SRA; ctrl_src_a = SRC_A_SHAMT; end
                    6'h04: ctrl_alu = ALU_SLL;
                    6'h06: ctrl_alu = ALU_SRL;
                    6'h07: ctrl_alu = ALU_SRA;
                    // Unknown funct decodes as a nop.
                    default: begin
                        ctrl_reg_dst = 1'b0;
                        ctrl_reg_wr  = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                ctrl_alu = ALU_ADD; ctrl_src_b = SRC_B_IMM;
                ctrl_ext = 1'b1;    ctrl_reg_wr = 1'b1;
            end
            6'h0A, 6'h0B: begin
                ctrl_alu = (op == 6'h0A) ? ALU_SLT : ALU_SLTU;
                ctrl_src_b = SRC_B_IMM;
                ctrl_ext = 1'b1;    ctrl_reg_wr = 1'b1;
            end
            6'h0C: begin
                ctrl_alu = ALU_AND; ctrl_src_b = SRC_B_IMM; ctrl_reg_wr = 1'b1;
            end
            6'h0D: begin
                ctrl_alu = ALU_OR;  ctrl_src_b = SRC_B_IMM; ctrl_reg_wr = 1'b1;
            end
            6'h0E: begin
                ctrl_alu = ALU_XOR; ctrl_src_b = SRC_B_IMM; ctrl_reg_wr = 1'b1;
            end
            6'h0F: begin
                ctrl_alu = ALU_SLL; ctrl_src_a = SRC_A_16;
                ctrl_src_b = SRC_B_IMM; ctrl_reg_wr = 1'b1;
            end
            6'h23: begin
                ctrl_alu = ALU_ADD; ctrl_src_b = SRC_B_IMM; ctrl_ext = 1'b1;
                ctrl_mem2reg = 1'b1; ctrl_reg_wr = 1'b1;
            end
            6'h2B: begin
                ctrl_alu = ALU_ADD; ctrl_src_b = SRC_B_IMM; ctrl_ext = 1'b1;
                ctrl_mem_wr = 1'b1;
            end
            6'h04: begin
                ctrl_alu = ALU_SUB; ctrl_ext = 1'b1; ctrl_branch = 2'b01;
            end
            6'h05: begin
                ctrl_alu = ALU_SUB; ctrl_ext = 1'b1; ctrl_branch = 2'b10;
            end
            6'h02: ctrl_jump = 1'b1;
            default: ;
        endcase
    end

    assign shamt = ex_in_a[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (ex_alu_op)
            ALU_ADD:  alu_out = ex_in_a + ex_in_b;
            ALU_SUB:  alu_out = ex_in_a - ex_in_b;
            ALU_AND:  alu_out = ex_in_a & ex_in_b;
            ALU_OR:   alu_out = ex_in_a | ex_in_b;
            ALU_XOR:  alu_out = ex_in_a ^ ex_in_b;
            ALU_NOR:  alu_out = ~(ex_in_a | ex_in_b);
            ALU_SLT:  alu_out = {31'd0, $signed(ex_in_a) < $signed(ex_in_b)};
            ALU_SLTU: alu_out = {31'd0, ex_in_a < ex_in_b};
            ALU_SLL:  alu_out = ex_in_b << shamt;
            ALU_SRL:  alu_out = ex_in_b >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(ex_in_b) >>> shamt);
            default:  alu_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            me_alu_out    <= 32'd0;
            me_store_data <= 32'd0;
            me_dst        <= 5'd0;
            me_mem2reg    <= 1'b0;
            me_mem_wr     <= 1'b0;
            me_reg_wr     <= 1'b0;
        end else begin
            me_alu_out    <= alu_out;
            me_store_data <= ex_store_data;
            me_dst        <= ex_dst;
            me_mem2reg    <= ex_mem2reg;
            me_mem_wr     <= ex_mem_wr;
            me_reg_wr     <= ex_reg_wr;
        end
    end

endmodule

// File: tb/tb_mips_ex_datapath_core.sv
// Randomized self-checking bench for mips_ex_datapath_core.
// Decode, ALU and EX/ME register are compared against a behavioural model.
module tb_mips_ex_datapath_core;

    typedef struct packed {
        logic [3:0] alu;
        logic       reg_dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       mem2reg;
        logic       ext;
        logic       reg_wr;
        logic       mem_wr;
        logic [1:0] branch;
        logic       jump;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op, funct;
    logic [3:0]  ctrl_alu;
    logic        ctrl_reg_dst;
    logic [1:0]  ctrl_src_a, ctrl_src_b;
    logic        ctrl_mem2reg, ctrl_ext, ctrl_reg_wr, ctrl_mem_wr;
    logic [1:0]  ctrl_branch;
    logic        ctrl_jump;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_in_a, ex_in_b, ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_mem2reg, ex_mem_wr, ex_reg_wr;
    logic [31:0] alu_out, me_alu_out, me_store_data;
    logic [4:0]  me_dst;
    logic        me_mem2reg, me_mem_wr, me_reg_wr;

    int n_tests = 0;
    int n_fail  = 0;

    dec_t        dec_obs;
    logic [72:0] me_obs;

    assign dec_obs = {ctrl_alu, ctrl_reg_dst, ctrl_src_a, ctrl_src_b,
                      ctrl_mem2reg, ctrl_ext, ctrl_reg_wr, ctrl_mem_wr,
                      ctrl_branch, ctrl_jump};
    assign me_obs = {me_alu_out, me_store_data, me_dst,
                     me_mem2reg, me_mem_wr, me_reg_wr};

    always #5 clk = ~clk;

    mips_ex_datapath_core dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .ctrl_alu(ctrl_alu), .ctrl_reg_dst(ctrl_reg_dst),
        .ctrl_src_a(ctrl_src_a), .ctrl_src_b(ctrl_src_b),
        .ctrl_mem2reg(ctrl_mem2reg), .ctrl_ext(ctrl_ext),
        .ctrl_reg_wr(ctrl_reg_wr), .ctrl_mem_wr(ctrl_mem_wr),
        .ctrl_branch(ctrl_branch), .ctrl_jump(ctrl_jump),
        .ex_alu_op(ex_alu_op), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_mem2reg(ex_mem2reg), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
        .alu_out(alu_out), .me_alu_out(me_alu_out),
        .me_store_data(me_store_data), .me_dst(me_dst),
        .me_mem2reg(me_mem2reg), .me_mem_wr(me_mem_wr), .me_reg_wr(me_reg_wr)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] code,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        longint sa, sb;
        sh = int'(a % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            4'd0:  return 32'(a + b);
            4'd1:  return 32'(a - b);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return 32'(longint'(b) * (longint'(1) << sh));
            4'd9:  return 32'(longint'(b) / (longint'(1) << sh));
            4'd10: return 32'(sb >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic dec_t dec_ref(input logic [5:0] o, input logic [5:0] f);
        dec_t d;
        d = '0;
        if (o == 6'h00) begin
            d.src_a = 2'd0;
            if (f == 6'h20 || f == 6'h21) d.alu = 4'd0;
            else if (f == 6'h22 || f == 6'h23) d.alu = 4'd1;
            else if (f >= 6'h24 && f <= 6'h27) d.alu = 4'(f - 6'h22);
            else if (f == 6'h2A) d.alu = 4'd6;
            else if (f == 6'h2B) d.alu = 4'd7;
            else if (f == 6'h00) begin d.alu = 4'd8;  d.src_a = 2'd2; end
            else if (f == 6'h02) begin d.alu = 4'd9;  d.src_a = 2'd2; end
            else if (f == 6'h03) begin d.alu = 4'd10; d.src_a = 2'd2; end
            else if (f == 6'h04) d.alu = 4'd8;
            else if (f == 6'h06) d.alu = 4'd9;
            else if (f == 6'h07) d.alu = 4'd10;
            else return '0;
            d.reg_dst = 1'b1;
            d.reg_wr  = 1'b1;
            return d;
        end
        if (o >= 6'h08 && o <= 6'h0F) begin
            d.src_b  = 2'd1;
            d.reg_wr = 1'b1;
            d.ext    = (o <= 6'h0B);
            if (o <= 6'h09) d.alu = 4'd0;
            else if (o == 6'h0A) d.alu = 4'd6;
            else if (o == 6'h0B) d.alu = 4'd7;
            else if (o == 6'h0F) begin d.alu = 4'd8; d.src_a = 2'd1; end
            else d.alu = 4'(o - 6'h0A);
        end else if (o == 6'h23 || o == 6'h2B) begin
            d.alu = 4'd0; d.src_b = 2'd1; d.ext = 1'b1;
            d.mem2reg = (o == 6'h23);
            d.reg_wr  = (o == 6'h23);
            d.mem_wr  = (o == 6'h2B);
        end else if (o == 6'h04 || o == 6'h05) begin
            d.alu = 4'd1; d.ext = 1'b1;
            d.branch = (o == 6'h04) ? 2'b01 : 2'b10;
        end else if (o == 6'h02) begin
            d.jump = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [72:0] me_ref(input logic [3:0] code,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] sd,
                                           input logic [4:0] dst,
                                           input logic m2r, input logic mw,
                                           input logic rw);
        return {alu_ref(code, a, b), sd, dst, m2r, mw, rw};
    endfunction

    task automatic drive_ex_random();
        ex_alu_op     = 4'($urandom_range(0, 10));
        ex_in_a       = $urandom;
        ex_in_b       = $urandom;
        ex_store_data = $urandom;
        ex_dst        = 5'($urandom_range(1, 31));
        ex_mem2reg    = 1'($urandom);
        ex_mem_wr     = 1'($urandom);
        ex_reg_wr     = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [72:0] exp_v;
        rst = 1'b0;
        op = 6'h00; funct = 6'h20;
        ex_alu_op = 4'd3; ex_in_a = 32'hA5A5_0F0F; ex_in_b = 32'h1234_5678;
        ex_store_data = 32'hDEAD_BEEF; ex_dst = 5'd17;
        ex_mem2reg = 1'b1; ex_mem_wr = 1'b1; ex_reg_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (me_obs !== 73'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] got %h want 0", i, me_obs);
            end
            drive_ex_random();
            ex_dst = 5'd31;
        end
        rst = 1'b1;
        exp_v = me_ref(ex_alu_op, ex_in_a, ex_in_b, ex_store_data, ex_dst,
                       ex_mem2reg, ex_mem_wr, ex_reg_wr);
        @(posedge clk); #1;
        n_tests++;
        if (me_obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release got %h want %h", me_obs, exp_v);
        end
    endtask

    task automatic test_decode_directed();
        op = 6'h00; funct = 6'h00; #1;
        n_tests++;
        if ({ctrl_alu, ctrl_src_a, ctrl_reg_dst, ctrl_reg_wr} !== {4'd8, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL dec_sll got alu=%0d sa=%0d rd=%b rw=%b", ctrl_alu,
                     ctrl_src_a, ctrl_reg_dst, ctrl_reg_wr);
        end
        op = 6'h0F; #1;
        n_tests++;
        if ({ctrl_alu, ctrl_src_a, ctrl_src_b, ctrl_ext} !== {4'd8, 2'd1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL dec_lui got alu=%0d sa=%0d sb=%0d ext=%b", ctrl_alu,
                     ctrl_src_a, ctrl_src_b, ctrl_ext);
        end
        op = 6'h2B; #1;
        n_tests++;
        if ({ctrl_mem_wr, ctrl_reg_wr} !== 2'b10) begin
            n_fail++;
            $display("FAIL dec_sw got mw=%b rw=%b want mw=1 rw=0", ctrl_mem_wr, ctrl_reg_wr);
        end
        op = 6'h05; #1;
        n_tests++;
        if (ctrl_branch !== 2'b10) begin
            n_fail++;
            $display("FAIL dec_bne got %b want 10", ctrl_branch);
        end
        op = 6'h02; #1;
        n_tests++;
        if (dec_obs !== 16'h0001) begin
            n_fail++;
            $display("FAIL dec_j got %h want 0001", dec_obs);
        end
        op = 6'h3F; #1;
        n_tests++;
        if (dec_obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL dec_nop got %h want 0000", dec_obs);
        end
        op = 6'h00; funct = 6'h01; #1;
        n_tests++;
        if (dec_obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL dec_bad_funct got %h want 0000", dec_obs);
        end
    endtask

    task automatic test_decode_random();
        dec_t e;
        for (int i = 0; i < 64; i++) begin
            op = 6'(i); funct = 6'($urandom); #1;
            e = dec_ref(op, funct);
            n_tests++;
            if (dec_obs !== e) begin
                n_fail++;
                $display("FAIL dec_op op=%h f=%h got %h want %h", op, funct, dec_obs, e);
            end
        end
        for (int i = 0; i < 64; i++) begin
            op = 6'h00; funct = 6'(i); #1;
            e = dec_ref(op, funct);
            n_tests++;
            if (dec_obs !== e) begin
                n_fail++;
                $display("FAIL dec_funct f=%h got %h want %h", funct, dec_obs, e);
            end
        end
    endtask

    task automatic test_alu_directed();
        logic [3:0]  codes [9] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd5,
                                   4'd8, 4'd10, 4'd9, 4'd8};
        logic [31:0] as [9] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd0, 32'd16, 32'd4, 32'd4, 32'h24};
        logic [31:0] bs [9] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0,
                                32'h0000_1234, 32'h8000_0000, 32'h8000_0000,
                                32'h0000_0001};
        logic [31:0] ex [9] = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF,
                                32'h1234_0000, 32'hF800_0000, 32'h0800_0000,
                                32'h0000_0010};
        for (int i = 0; i < 9; i++) begin
            ex_alu_op = codes[i]; ex_in_a = as[i]; ex_in_b = bs[i]; #1;
            n_tests++;
            if (alu_out !== ex[i]) begin
                n_fail++;
                $display("FAIL alu_dir[%0d] op=%0d got %h want %h", i, codes[i], alu_out, ex[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] e;
        for (int i = 0; i < 400; i++) begin
            ex_alu_op = 4'(i % 16);
            ex_in_a = $urandom;
            ex_in_b = $urandom;
            if (i % 5 == 0) ex_in_b = ex_in_a;
            #1;
            e = alu_ref(ex_alu_op, ex_in_a, ex_in_b);
            n_tests++;
            if (alu_out !== e) begin
                n_fail++;
                $display("FAIL alu_rand op=%0d a=%h b=%h got %h want %h",
                         ex_alu_op, ex_in_a, ex_in_b, alu_out, e);
            end
        end
    endtask

    task automatic test_latency();
        logic [72:0] e;
        ex_alu_op = 4'd0; ex_in_a = 32'd5; ex_in_b = 32'd3;
        ex_store_data = 32'd0; ex_dst = 5'd9;
        ex_mem2reg = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b1;
        e = {32'd8, 32'd0, 5'd9, 1'b0, 1'b0, 1'b1};
        @(posedge clk); #1;
        n_tests++;
        if (me_obs !== e) begin
            n_fail++;
            $display("FAIL latency got %h want %h", me_obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] q[$];
        logic [72:0] e;
        for (int i = 0; i < 40; i++) begin
            drive_ex_random();
            ex_alu_op = 4'd0;
            ex_mem2reg = (i % 2 == 0);
            ex_mem_wr  = (i % 2 == 1);
            ex_reg_wr  = (i % 2 == 0);
            q.push_back(me_ref(ex_alu_op, ex_in_a, ex_in_b, ex_store_data,
                               ex_dst, ex_mem2reg, ex_mem_wr, ex_reg_wr));
            @(posedge clk); #1;
            e = q.pop_front();
            n_tests++;
            if (me_obs !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h want %h", i, me_obs, e);
            end
        end
        for (int i = 0; i < 40; i++) begin
            drive_ex_random();
            q.push_back(me_ref(ex_alu_op, ex_in_a, ex_in_b, ex_store_data,
                               ex_dst, ex_mem2reg, ex_mem_wr, ex_reg_wr));
            @(posedge clk); #1;
            e = q.pop_front();
            n_tests++;
            if (me_obs !== e) begin
                n_fail++;
                $display("FAIL b2b_rand[%0d] got %h want %h", i, me_obs, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_ex_random();
        ex_dst = 5'd7;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (me_obs !== 73'd0) begin
            n_fail++;
            $display("FAIL mid_reset got %h want 0", me_obs);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_decode_directed();
        test_decode_random();
        test_alu_directed();
        test_alu_random();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
